// File: rtl/arb_rr8.sv
// Eight-way round-robin arbiter with a registered one-hot grant.
// Defining ARB_RR8_TIMEOUT_EN adds a hold counter that forces a grant to be released after HOLD_MAX cycles.
module arb_rr8 #(
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  // Handshake: a grant is live exactly while gnt_valid=1 (gnt_valid mirrors state==GRANT).
  // It ends on the edge where the grantee drops its req bit or pulses done.
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_hold
    $error("arb_rr8: HOLD_MAX must be in 2..255");
  end

  state_t     state, state_nx;
  logic [2:0] ptr, ptr_nx;
  logic [2:0] idx_nx;
  logic [7:0] gnt_nx;
  logic       valid_nx, timeout_nx;
  logic [2:0] pick, cand;
  logic       pick_any;
  logic       release_now, forced;

`ifdef ARB_RR8_TIMEOUT_EN
  logic [7:0] hold_cnt, hold_nx;
  // hold_cnt is 0 during the first GRANT cycle, so HOLD_MAX-1 marks the last allowed one.
  assign forced = (hold_cnt == 8'(HOLD_MAX - 1)) && !release_now;
`else
  assign forced = 1'b0;
`endif

  assign release_now = done || !req[gnt_idx];

  // The lowest offset from ptr wins, so scan from the far end and let nearer hits overwrite.
  always_comb begin
    pick_any = 1'b0;
    pick     = ptr;
    cand     = ptr;
    for (int k = 7; k >= 0; k--) begin
      cand = ptr + 3'(k);
      if (req[cand]) begin
        pick_any = 1'b1;
        pick     = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 3'd0;
      gnt       <= 8'h00;
      gnt_idx   <= 3'd0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
`ifdef ARB_RR8_TIMEOUT_EN
      hold_cnt  <= 8'd0;
`endif
    end else begin
      state     <= state_nx;
      ptr       <= ptr_nx;
      gnt       <= gnt_nx;
      gnt_idx   <= idx_nx;
      gnt_valid <= valid_nx;
      timeout   <= timeout_nx;
`ifdef ARB_RR8_TIMEOUT_EN
      hold_cnt  <= hold_nx;
`endif
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (pick_any) state_nx = GRANT;
      GRANT:   if (release_now || forced) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Next values of the registered outputs; done is ignored while idle.
  always_comb begin
    gnt_nx     = gnt;
    idx_nx     = gnt_idx;
    valid_nx   = gnt_valid;
    timeout_nx = 1'b0;
    ptr_nx     = ptr;
`ifdef ARB_RR8_TIMEOUT_EN
    hold_nx    = hold_cnt;
`endif
    case (state)
      IDLE: begin
        if (pick_any) begin
          idx_nx   = pick;
          gnt_nx   = 8'd1 << pick;
          valid_nx = 1'b1;
`ifdef ARB_RR8_TIMEOUT_EN
          hold_nx  = 8'd0;
`endif
        end else begin
          gnt_nx   = 8'h00;
          valid_nx = 1'b0;
        end
      end
      GRANT: begin
        if (release_now || forced) begin
          gnt_nx     = 8'h00;
          valid_nx   = 1'b0;
          ptr_nx     = gnt_idx + 3'd1;
          timeout_nx = forced;
        end else begin
`ifdef ARB_RR8_TIMEOUT_EN
          hold_nx = hold_cnt + 8'd1;
`endif
        end
      end
      default: begin
        gnt_nx   = 8'h00;
        valid_nx = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_arb_rr8.sv
// Bench for arb_rr8: directed scenarios plus random traffic, all compared against a queue of model predictions.
// The model's timeout behaviour follows ARB_RR8_TIMEOUT_EN.
module tb_arb_rr8;

  localparam int HM = 4;
`ifdef ARB_RR8_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = 8'h00;
  logic       done = 1'b0;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  always #5 clk = ~clk;

  arb_rr8 #(.HOLD_MAX(HM)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .timeout(timeout)
  );

  // Scoreboard entries are {gnt, gnt_idx, gnt_valid, timeout}.
  logic [12:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  // Reference model: who holds the resource, for how many cycles so far, and where the search starts.
  bit m_busy;
  int m_idx, m_ptr, m_held;
  bit m_to;

  function automatic logic [12:0] dut_word();
    return {gnt, gnt_idx, gnt_valid, timeout};
  endfunction

  function automatic logic [12:0] model_word();
    logic [7:0] g;
    g = m_busy ? 8'(1 << m_idx) : 8'h00;
    return {g, 3'(m_idx), m_busy, m_to};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp_v);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_idx = 0; m_ptr = 0; m_held = 0; m_to = 1'b0;
  endtask

  task automatic model_step(input logic [7:0] r, input logic d);
    bit found;
    m_to = 1'b0;
    if (!m_busy) begin
      found = 1'b0;
      for (int k = 0; k < 8; k++) begin
        if (!found && r[(m_ptr + k) % 8]) begin
          found = 1'b1;
          m_idx = (m_ptr + k) % 8;
        end
      end
      if (found) begin
        m_busy = 1'b1;
        m_held = 1;
      end
    end else if (d || !r[m_idx]) begin
      m_busy = 1'b0;
      m_ptr  = (m_idx + 1) % 8;
    end else if (TO_EN && m_held == HM) begin
      m_busy = 1'b0;
      m_ptr  = (m_idx + 1) % 8;
      m_to   = 1'b1;
    end else begin
      m_held++;
    end
  endtask

  // Apply inputs for one clock edge, then queue the model's view of the result.
  task automatic cycle(input logic [7:0] r, input logic d);
    req  = r;
    done = d;
    @(posedge clk);
    model_step(r, d);
    exp_q.push_back(model_word());
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 chk("reset_async", 32'(dut_word()), 32'd0);
    model_reset();
    #1 rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) chk("scoreboard", 32'(dut_word()), 32'(exp_q.pop_front()));
  end

  logic [7:0] seq [9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
  logic [7:0] r_prev;

  initial begin
    model_reset();
    #2 chk("reset_state", 32'(dut_word()), 32'd0);
    #10 rst_n = 1'b1;

    // Idle with no requests; done must be ignored.
    repeat (10) cycle(8'h00, 1'($urandom_range(0, 1)));

    cycle(8'h81, 1'b0);
    chk("r81_first", 32'(gnt), 32'h01);
    cycle(8'h81, 1'b1);
    chk("r81_gap", 32'(gnt), 32'h00);
    cycle(8'h81, 1'b0);
    chk("r81_second", 32'({gnt, gnt_idx}), 32'({8'h80, 3'd7}));
    cycle(8'h81, 1'b1);
    cycle(8'h00, 1'b0);

    do_reset();
    for (int i = 0; i < 9; i++) begin
      cycle(8'hFF, 1'b0);
      chk("rr_seq", 32'(gnt), 32'(seq[i]));
      cycle(8'hFF, 1'b1);
    end

    // Long hold: held forever by default, periodic forced release with the timeout.
    do_reset();
    repeat (110) cycle(8'h04, 1'b0);
    cycle(8'h00, 1'b0);

    do_reset();
    cycle(8'h08, 1'b0);
    chk("idx3_grant", 32'(gnt), 32'h08);
    cycle(8'h00, 1'b0);
    chk("idx3_drop", 32'(gnt), 32'h00);
    cycle(8'h0F, 1'b0);
    chk("wrap_after_drop", 32'(gnt), 32'h01);
    cycle(8'h0F, 1'b1);

    do_reset();
    cycle(8'hFF, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(8'hFF, 1'b1);
      cycle(8'hFF, 1'b0);
    end
    chk("grant_idx5", 32'(gnt), 32'h20);
    do_reset();
    cycle(8'hFF, 1'b0);
    chk("after_mid_reset", 32'(gnt), 32'h01);

    r_prev = 8'h00;
    for (int i = 0; i < 800; i++) begin
      logic [7:0] r;
      if ($urandom_range(0, 1) == 0) r = r_prev;
      else if ($urandom_range(0, 4) == 0) r = 8'h00;
      else r = 8'($urandom);
      r_prev = r;
      cycle(r, $urandom_range(0, 7) == 0);
      if ($urandom_range(0, 199) == 0) do_reset();
    end

    cycle(8'h00, 1'b0);
    @(negedge clk);
    #1 chk("queue_drain", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
